// File: rtl/maquina_preparo.sv
// Drink-preparation sequencer: runs a timed per-drink recipe on a rising-edge "chosen" trigger.
// Outputs decode combinationally from the registered state and the latched drink code.
module maquina_preparo #(
  parameter logic [15:0] T_AQUECE  = 16'd500,
  parameter logic [15:0] T_PO      = 16'd200,
  parameter logic [15:0] T_CHA     = 16'd300,
  parameter logic [15:0] T_AGUA    = 16'd400,
  parameter logic [15:0] T_LEITE   = 16'd250,
  parameter logic [15:0] T_ESPUMA  = 16'd150,
  parameter logic [15:0] T_ENTREGA = 16'd100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] SAIDA,
  input  logic [3:0] BEBIDA,
  input  logic       COPO,
  output logic       AQUECEDOR,
  output logic       V_PO,
  output logic       V_CHA,
  output logic       V_AGUA,
  output logic       V_LEITE,
  output logic       V_ESPUMA,
  output logic       OCUPADO,
  output logic       PRONTO,
  output logic       ERRO,
  output logic [3:0] FASE
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    AQUECE    = 4'd1,
    BASE      = 4'd2,
    AGUA      = 4'd3,
    LEITE     = 4'd4,
    ESPUMA    = 4'd5,
    ENTREGA   = 4'd6,
    CONCLUIDO = 4'd7,
    FALHA     = 4'd8
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [3:0]  drink;
  logic [3:0]  drink_nxt;
  logic [1:0]  saida_prev;
  logic        trig;
  logic        drink_ok;
  logic        in_phase_nxt;

  function automatic state_t next_phase(input state_t s, input logic [3:0] d);
    case (s)
      AQUECE:  next_phase = BASE;
      BASE:    next_phase = AGUA;
      AGUA:    next_phase = (d == 4'd2 || d == 4'd4) ? LEITE : ENTREGA;
      LEITE:   next_phase = (d == 4'd4) ? ESPUMA : ENTREGA;
      ESPUMA:  next_phase = ENTREGA;
      ENTREGA: next_phase = CONCLUIDO;
      default: next_phase = OCIOSO;
    endcase
  endfunction

  function automatic logic [15:0] phase_len(input state_t s, input logic [3:0] d);
    case (s)
      AQUECE:  phase_len = T_AQUECE;
      BASE:    phase_len = (d == 4'd3) ? T_CHA : T_PO;
      AGUA:    phase_len = T_AGUA;
      LEITE:   phase_len = T_LEITE;
      ESPUMA:  phase_len = T_ESPUMA;
      ENTREGA: phase_len = T_ENTREGA;
      default: phase_len = 16'd1;
    endcase
  endfunction

  assign trig     = (SAIDA == 2'b11) && (saida_prev != 2'b11) && (state == OCIOSO);
  assign drink_ok = (BEBIDA >= 4'd1) && (BEBIDA <= 4'd4);
  assign drink_nxt = trig ? BEBIDA : drink;
  assign in_phase_nxt = (state_nxt >= AQUECE) && (state_nxt <= ENTREGA);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= OCIOSO;
    end else begin
      state <= state_nxt;
    end
  end

  // Cup loss is tested before phase completion so it wins in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO: begin
        if (trig) begin
          state_nxt = (drink_ok && COPO) ? AQUECE : FALHA;
        end
      end
      AQUECE, BASE, AGUA, LEITE, ESPUMA, ENTREGA: begin
        if (!COPO) begin
          state_nxt = FALHA;
        end else if (cnt == 16'd0) begin
          state_nxt = next_phase(state, drink);
        end
      end
      CONCLUIDO, FALHA: begin
        if (!COPO) begin
          state_nxt = OCIOSO;
        end
      end
      default: state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= 16'd0;
      drink      <= 4'd0;
      saida_prev <= 2'b00;
    end else begin
      saida_prev <= SAIDA;
      drink      <= drink_nxt;
      if (state_nxt != state && in_phase_nxt) begin
        cnt <= phase_len(state_nxt, drink_nxt) - 16'd1;
      end else if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  always_comb begin
    AQUECEDOR = 1'b0;
    V_PO      = 1'b0;
    V_CHA     = 1'b0;
    V_AGUA    = 1'b0;
    V_LEITE   = 1'b0;
    V_ESPUMA  = 1'b0;
    OCUPADO   = 1'b0;
    PRONTO    = 1'b0;
    ERRO      = 1'b0;
    FASE      = state;
    case (state)
      AQUECE: begin
        AQUECEDOR = 1'b1;
        OCUPADO   = 1'b1;
      end
      BASE: begin
        V_PO    = (drink != 4'd3);
        V_CHA   = (drink == 4'd3);
        OCUPADO = 1'b1;
      end
      AGUA: begin
        AQUECEDOR = 1'b1;
        V_AGUA    = 1'b1;
        OCUPADO   = 1'b1;
      end
      LEITE: begin
        V_LEITE = 1'b1;
        OCUPADO = 1'b1;
      end
      ESPUMA: begin
        V_ESPUMA = 1'b1;
        OCUPADO  = 1'b1;
      end
      ENTREGA:   OCUPADO = 1'b1;
      CONCLUIDO: PRONTO  = 1'b1;
      FALHA:     ERRO    = 1'b1;
      default:   FASE    = state;
    endcase
  end

endmodule

// File: tb/tb_maquina_preparo.sv
// Bench for maquina_preparo: table of drink requests plus hand-written cup-loss and reset sequences.
module tb_maquina_preparo;

  logic       CLK;
  logic       RST_N;
  logic [1:0] SAIDA;
  logic [3:0] BEBIDA;
  logic       COPO;
  logic       AQUECEDOR, V_PO, V_CHA, V_AGUA, V_LEITE, V_ESPUMA;
  logic       OCUPADO, PRONTO, ERRO;
  logic [3:0] FASE;

  typedef struct packed {
    logic [3:0] fase;
    logic aq, po, cha, agua, leite, esp, ocup, pronto, erro;
  } out_t;

  typedef struct {
    logic [3:0] bebida;
    logic       copo;
    int         end_idx;
    int         end_fase;
    int         po_cyc;
    int         cha_cyc;
    int         esp_cyc;
    int         aq_cyc;
  } vec_t;

  out_t obs;
  out_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  maquina_preparo #(
    .T_AQUECE(16'd4), .T_PO(16'd2), .T_CHA(16'd3), .T_AGUA(16'd5),
    .T_LEITE(16'd3), .T_ESPUMA(16'd2), .T_ENTREGA(16'd2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SAIDA(SAIDA), .BEBIDA(BEBIDA), .COPO(COPO),
    .AQUECEDOR(AQUECEDOR), .V_PO(V_PO), .V_CHA(V_CHA), .V_AGUA(V_AGUA),
    .V_LEITE(V_LEITE), .V_ESPUMA(V_ESPUMA), .OCUPADO(OCUPADO),
    .PRONTO(PRONTO), .ERRO(ERRO), .FASE(FASE)
  );

  assign obs = {FASE, AQUECEDOR, V_PO, V_CHA, V_AGUA, V_LEITE, V_ESPUMA, OCUPADO, PRONTO, ERRO};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic out_t model(input int f, input logic [3:0] d);
    out_t o;
    o        = '0;
    o.fase   = 4'(f);
    o.aq     = (f == 1 || f == 3);
    o.po     = (f == 2 && d != 4'd3);
    o.cha    = (f == 2 && d == 4'd3);
    o.agua   = (f == 3);
    o.leite  = (f == 4);
    o.esp    = (f == 5);
    o.ocup   = (f >= 1 && f <= 6);
    o.pronto = (f == 7);
    o.erro   = (f == 8);
    return o;
  endfunction

  function automatic int tdur(input int f, input logic [3:0] d);
    case (f)
      1: return 4;
      2: return (d == 4'd3) ? 3 : 2;
      3: return 5;
      4: return 3;
      5: return 2;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for every cycle from the trigger edge up to the first terminal cycle.
  task automatic push_recipe(input logic [3:0] d, input logic c);
    int seq[$];
    if (d < 4'd1 || d > 4'd4 || !c) begin
      q.push_back(model(8, d));
    end else begin
      seq = '{1, 2, 3};
      if (d == 4'd2 || d == 4'd4) seq.push_back(4);
      if (d == 4'd4) seq.push_back(5);
      seq.push_back(6);
      foreach (seq[i]) begin
        for (int r = 0; r < tdur(seq[i], d); r++) q.push_back(model(seq[i], d));
      end
      q.push_back(model(7, d));
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_pop(input string name);
    out_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed %h", name, obs);
    end else begin
      e = q.pop_front();
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: got fase=%0d outs=%b, expected fase=%0d outs=%b",
                 name, obs.fase, obs[8:0], e.fase, e[8:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int n, fin, fin_fase, po_c, cha_c, esp_c, aq_c;

    vecs[0] = '{4'd1,  1'b1, 13, 7, 2, 0, 0, 9};
    vecs[1] = '{4'd2,  1'b1, 16, 7, 2, 0, 0, 9};
    vecs[2] = '{4'd3,  1'b1, 14, 7, 0, 3, 0, 9};
    vecs[3] = '{4'd4,  1'b1, 18, 7, 2, 0, 2, 9};
    vecs[4] = '{4'd5,  1'b1,  0, 8, 0, 0, 0, 0};
    vecs[5] = '{4'd0,  1'b1,  0, 8, 0, 0, 0, 0};
    vecs[6] = '{4'd1,  1'b0,  0, 8, 0, 0, 0, 0};
    vecs[7] = '{4'd15, 1'b1,  0, 8, 0, 0, 0, 0};

    RST_N = 1'b0; SAIDA = 2'b00; BEBIDA = 4'd0; COPO = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    q.push_back(model(0, 0));
    check_pop("reset_state");
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      SAIDA = 2'b00; BEBIDA = vecs[i].bebida; COPO = vecs[i].copo;
      step();
      SAIDA = 2'b11;
      push_recipe(vecs[i].bebida, vecs[i].copo);
      n = q.size();
      fin = -1; fin_fase = -1; po_c = 0; cha_c = 0; esp_c = 0; aq_c = 0;
      for (int c = 0; c < n; c++) begin
        step();
        po_c += int'(V_PO); cha_c += int'(V_CHA); esp_c += int'(V_ESPUMA); aq_c += int'(AQUECEDOR);
        if (fin < 0 && FASE >= 4'd7) begin
          fin = c;
          fin_fase = int'(FASE);
        end
        check_pop($sformatf("vec%0d_cyc%0d", i, c));
      end
      check_val($sformatf("vec%0d_end_cycle", i), fin, vecs[i].end_idx);
      check_val($sformatf("vec%0d_end_fase", i), fin_fase, vecs[i].end_fase);
      check_val($sformatf("vec%0d_po_cycles", i), po_c, vecs[i].po_cyc);
      check_val($sformatf("vec%0d_cha_cycles", i), cha_c, vecs[i].cha_cyc);
      check_val($sformatf("vec%0d_esp_cycles", i), esp_c, vecs[i].esp_cyc);
      check_val($sformatf("vec%0d_heat_cycles", i), aq_c, vecs[i].aq_cyc);
      COPO = 1'b0;
      q.push_back(model(0, 0));
      step();
      check_pop($sformatf("vec%0d_cup_removed", i));
    end

    // Cup removed during the milk phase of cafe com leite.
    SAIDA = 2'b00; BEBIDA = 4'd2; COPO = 1'b1;
    step();
    SAIDA = 2'b11;
    push_recipe(4'd2, 1'b1);
    for (int c = 0; c < 13; c++) begin
      step();
      check_pop($sformatf("loss_pre_cyc%0d", c));
    end
    q.delete();
    COPO = 1'b0;
    q.push_back(model(8, 2));
    step();
    check_pop("loss_to_falha");
    q.push_back(model(0, 0));
    step();
    check_pop("loss_to_ocioso");
    COPO = 1'b1;
    for (int c = 0; c < 3; c++) begin
      q.push_back(model(0, 0));
      step();
      check_pop($sformatf("loss_no_retrigger%0d", c));
    end

    // Asynchronous reset in the water phase, then one restart from the held trigger.
    SAIDA = 2'b00; BEBIDA = 4'd1; COPO = 1'b1;
    step();
    SAIDA = 2'b11;
    push_recipe(4'd1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      step();
      check_pop($sformatf("rst_pre_cyc%0d", c));
    end
    q.delete();
    #3 RST_N = 1'b0;
    #1;
    q.push_back(model(0, 0));
    check_pop("async_reset_outputs");
    @(posedge CLK);
    #2 RST_N = 1'b1;
    push_recipe(4'd1, 1'b1);
    n = q.size();
    for (int c = 0; c < n; c++) begin
      step();
      check_pop($sformatf("rst_restart_cyc%0d", c));
    end
    for (int c = 0; c < 2; c++) begin
      q.push_back(model(7, 1));
      step();
      check_pop($sformatf("rst_hold_done%0d", c));
    end
    COPO = 1'b0;
    q.push_back(model(0, 0));
    step();
    check_pop("rst_cup_removed");
    COPO = 1'b1;
    for (int c = 0; c < 3; c++) begin
      q.push_back(model(0, 0));
      step();
      check_pop($sformatf("rst_single_start%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maquina_preparo.md
# maquina_preparo

Drink-preparation sequencer of the coffee machine, directly downstream of the drink-selection FSM. It consumes the selection status code and the 4-bit drink code, then runs a per-drink recipe. Each recipe is a fixed sequence of timed phases (heat, base dose, water, milk, foam, delivery) driving the valve and heater outputs. It reports busy/done/error and the current phase for the display.

## Interface
Phase durations, in CLK cycles, each ≥1:
- T_AQUECE, 16'd500: heating phase.
- T_PO, 16'd200: coffee-powder dose.
- T_CHA, 16'd300: tea dose.
- T_AGUA, 16'd400: water dose.
- T_LEITE, 16'd250: milk dose.
- T_ESPUMA, 16'd150: foam phase.
- T_ENTREGA, 16'd100: delivery/drip phase.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SAIDA  in  2  selection status: 00 idle, 01 selecting, 10 timeout, 11 chosen.
- BEBIDA  in  4  drink code: 1 espresso, 2 café com leite, 3 chá, 4 cappuccino.
- COPO  in  1  cup-present sensor, high = present.
- AQUECEDOR, V_PO, V_CHA, V_AGUA, V_LEITE, V_ESPUMA  out  1 each  heater and valves.
- OCUPADO  out  1  a recipe is running (AQUECE..ENTREGA).
- PRONTO  out  1  drink finished, waiting for cup removal.
- ERRO  out  1  aborted or invalid request.
- FASE  out  4  current state code.

## Operation
- States and FASE codes:
  - OCIOSO=0, AQUECE=1, BASE=2, AGUA=3, LEITE=4, ESPUMA=5, ENTREGA=6.
  - CONCLUIDO=7, FALHA=8.
- Trigger:
  - Condition: SAIDA==11 while the registered previous SAIDA !=11 (rising-edge detect) and state is OCIOSO.
  - Triggers in any other state are ignored.
  - The edge register updates every cycle, so a held 11 never retriggers.
- On trigger, BEBIDA is latched. Next state:
  - FALHA if the latched code is not in 1..4, or if COPO==0.
  - AQUECE otherwise.
- Recipes, each ending in ENTREGA then CONCLUIDO:
  - 1: AQUECE, BASE(PO), AGUA.
  - 2: AQUECE, BASE(PO), AGUA, LEITE.
  - 3: AQUECE, BASE(CHA), AGUA.
  - 4: AQUECE, BASE(PO), AGUA, LEITE, ESPUMA.
- BASE duration is T_PO for drinks 1, 2 and 4, and T_CHA for drink 3.
- Outputs are decoded from the registered state and latched drink:
  - AQUECEDOR=1 in AQUECE and AGUA.
  - V_PO=1 in BASE for drinks 1, 2, 4; V_CHA=1 in BASE for drink 3.
  - V_AGUA=1 in AGUA, V_LEITE=1 in LEITE, V_ESPUMA=1 in ESPUMA.
  - OCUPADO=1 for FASE 1..6, PRONTO=1 in CONCLUIDO, ERRO=1 in FALHA.
- Cup loss: COPO==0 in any of AQUECE..ENTREGA moves to FALHA at the next edge. All valves and the heater drop that cycle.
- CONCLUIDO and FALHA hold until COPO==0 is sampled, then return to OCIOSO.
- Counter: a 16-bit phase counter is loaded with T-1 on phase entry and decrements each cycle. The phase ends when it reads 0 and is not running.

## Timing
- Reset (async, RST_N low):
  - State goes to OCIOSO and all outputs to 0, FASE=0.
  - Counter, latched drink and the previous-SAIDA register are cleared to 0.
  - Because previous-SAIDA clears to 00, an SAIDA held at 11 through reset release triggers exactly once after reset.
- Reset mid-recipe: valves and heater go low immediately, without waiting for CLK.
- Trigger sampled at edge k puts the block in AQUECE (or FALHA) from edge k. There is no extra latency.
- A phase entered at edge j lasts exactly T cycles; the next state is registered at edge j+T.
- CONCLUIDO is reached at edge k + sum of the recipe's phase durations.
- Precedence within a cycle: reset > cup loss > phase completion.
- The trigger is evaluated only in OCIOSO.
- FALHA/CONCLUIDO last at least one cycle. If COPO is already 0 on entry, the block exits at the following edge.

## Test plan
Bench parameters: T_AQUECE=4, T_PO=2, T_CHA=3, T_AGUA=5, T_LEITE=3, T_ESPUMA=2, T_ENTREGA=2.
- Espresso: COPO=1, BEBIDA=1, SAIDA 00→11 at edge k.
  - AQUECEDOR cycles k..k+3, V_PO k+4..k+5, V_AGUA k+6..k+10, ENTREGA k+11..k+12.
  - PRONTO from k+13. Dropping COPO returns FASE to 0 one edge later.
- Cappuccino, BEBIDA=4: FASE sequence 1,2,3,4,5,6,7 with PRONTO at k+18. V_ESPUMA is high for exactly 2 cycles.
- Chá, BEBIDA=3: V_CHA high 3 cycles and V_PO never high. PRONTO at k+14.
- BEBIDA=5 with a trigger: FALHA (FASE=8, ERRO=1) at edge k, no valve ever high. COPO→0 returns to OCIOSO.
- COPO→0 during LEITE of drink 2: next edge gives FASE=8, V_LEITE=0, OCUPADO=0. SAIDA held at 11 afterwards causes no retrigger.
- RST_N pulsed low mid-AGUA: all outputs 0 asynchronously. With SAIDA held at 11 after release, exactly one new recipe starts.
